// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA sequencer and mem port arbiter (clk/reset; cpu_addr/cpu_we/cpu_dout in, mem_addr/mem_we/mem_dout/mem_din to mem, cpu_rdy/dma_busy/dma_done status)
module oam_dma_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [REG_WIDTH-1:0]  cpu_dout,
  input  logic [REG_WIDTH-1:0]  mem_din,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  cpu_rdy,
  output logic                  dma_busy,
  output logic                  dma_done
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_nx;
  logic [7:0] page, idx;
  logic parity, trig, last;
  logic [ADDR_WIDTH-1:0] src;
  always_comb begin
    trig = state == IDLE && cpu_we && cpu_addr == DMA_REG_ADDR;
    last = state == WRITE && idx == 8'hff;
    src = ADDR_WIDTH'({page, idx});
    state_nx = state;
    case (state)
      IDLE:    state_nx = trig ? HALT : IDLE;
      HALT:    state_nx = parity ? READ : ALIGN;
      ALIGN:   state_nx = READ;
      READ:    state_nx = WRITE;
      WRITE:   state_nx = last ? IDLE : READ;
      default: state_nx = IDLE;
    endcase
    cpu_rdy = reset || state == IDLE;
    dma_busy = !cpu_rdy;
    mem_addr = cpu_rdy ? cpu_addr : state == WRITE ? OAM_DATA_ADDR : src;
    mem_we = !reset && (state == IDLE ? cpu_we && !trig : state == WRITE);
    mem_dout = dma_busy && state == WRITE ? mem_din : cpu_dout;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      page <= 8'd0;
      idx <= 8'd0;
      parity <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      state <= state_nx;
      parity <= !parity;
      dma_done <= last;
      if (trig) begin
        page <= 8'(cpu_dout);
        idx <= 8'd0;
      end else if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: cycle model and directed transfers for oam_dma_ctrl
module tb_oam_dma_ctrl;
  logic clk = 1'b0, reset = 1'b1, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0] cpu_dout = 8'h00, mem_din = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0] mem_dout;
  logic mem_we, cpu_rdy, dma_busy, dma_done;
  always #5 clk = ~clk;
  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
    .cpu_rdy(cpu_rdy), .dma_busy(dma_busy), .dma_done(dma_done)
  );
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA7;
  endfunction
  logic [7:0] mem_arr [65536];
  bit wr_v [65536];
  always @(posedge clk) begin
    mem_din <= wr_v[mem_addr] ? mem_arr[mem_addr] : pat(mem_addr);
    if (mem_we) begin
      mem_arr[mem_addr] <= mem_dout;
      wr_v[mem_addr] <= 1'b1;
    end
  end
  int cyc = 0, t0 = 0, end_c = -1;
  bit act = 1'b0, started = 1'b0;
  logic [7:0] mp = 8'h00;
  always @(posedge clk) begin
    if (reset) begin
      cyc <= 0;
      act <= 1'b0;
      end_c <= -1;
      started <= 1'b1;
    end else begin
      if (!(act && cyc > t0 && cyc < end_c) && cpu_we && cpu_addr == 16'h4014) begin
        act <= 1'b1;
        t0 <= cyc;
        mp <= cpu_dout;
        end_c <= cyc + 514 + cyc % 2;
      end
      cyc <= cyc + 1;
    end
  end
  int vectors = 0, miscompares = 0;
  int stall = 0, wr_cnt = 0, done_cnt = 0, order_err = 0, min_rd = 0, max_rd = 0, trig_c = 0;
  logic [7:0] mon_page = 8'h00, first_wd = 8'h00, last_wd = 8'h00;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (started) begin : cmp
      bit busy;
      int r0, k;
      logic [15:0] ea;
      logic ew, dchk;
      logic [7:0] ed;
      busy = act && cyc > t0 && cyc < end_c;
      r0 = t0 + 2 + t0 % 2;
      k = (cyc - r0) / 2;
      ea = cpu_addr;
      ew = cpu_we && cpu_addr != 16'h4014;
      ed = cpu_dout;
      dchk = 1'b1;
      if (reset) ew = 1'b0;
      else if (busy) begin
        dchk = 1'b0;
        ew = 1'b0;
        ea = {mp, 8'h00};
        if (cyc >= r0) begin
          ea = {mp, 8'(k)};
          if ((cyc - r0) % 2 == 1) begin
            ea = 16'h2004;
            ew = 1'b1;
            ed = pat({mp, 8'(k)});
            dchk = 1'b1;
          end
        end
      end
      chk("mem_addr", mem_addr, ea);
      chk("mem_we", mem_we, ew);
      chk("cpu_rdy", cpu_rdy, reset || !busy);
      chk("dma_busy", dma_busy, !reset && busy);
      if (dchk) chk("mem_dout", mem_dout, ed);
      if (!reset) chk("dma_done", dma_done, act && cyc == end_c);
      if (!reset) begin
        if (!cpu_rdy) stall++;
        if (dma_done) done_cnt++;
        if (mem_we && mem_addr == 16'h2004) begin
          if (wr_cnt == 0) first_wd = mem_dout;
          last_wd = mem_dout;
          if (mem_dout !== pat({mon_page, 8'(wr_cnt)})) order_err++;
          wr_cnt++;
        end
        if (dma_busy && !mem_we) begin
          if (int'(mem_addr) < min_rd) min_rd = int'(mem_addr);
          if (int'(mem_addr) > max_rd) max_rd = int'(mem_addr);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
    cpu_addr = a;
    cpu_we = w;
    cpu_dout = d;
  endtask
  task automatic clr();
    stall = 0;
    wr_cnt = 0;
    done_cnt = 0;
    order_err = 0;
    min_rd = 32'hffff;
    max_rd = 0;
  endtask
  task automatic to_parity(input int want);
    drive(16'h0300, 1'b0, 8'h00);
    while (cyc % 2 != want) step();
  endtask
  task automatic trig(input logic [7:0] p);
    drive(16'h4014, 1'b1, p);
    mon_page = p;
    trig_c = cyc;
    step();
    drive(16'h0300, 1'b0, 8'h00);
    clr();
  endtask
  task automatic wait_done(input bit inj);
    bit got = 1'b0;
    for (int i = 1; i <= 700 && !got; i++) begin
      if (inj && (i == 10 || i == 100)) drive(16'h4014, 1'b1, 8'h55);
      else drive(16'h0300, 1'b0, 8'h00);
      step();
      got = dma_done;
    end
    drive(16'h0300, 1'b0, 8'h00);
    chk("done_seen", got, 1);
  endtask
  task automatic xfer_checks(input int exp_stall, input logic [7:0] fw, input logic [7:0] lw);
    step();
    chk("stall_len", stall, exp_stall);
    chk("oam_writes", wr_cnt, 256);
    chk("done_pulses", done_cnt, 1);
    chk("order_errs", order_err, 0);
    chk("first_data", first_wd, fw);
    chk("last_data", last_wd, lw);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(16'h0000, 1'b0, 8'h00);
    repeat (3) step();
    reset = 1'b0;
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_busy", dma_busy, 0);
    chk("rst_done", dma_done, 0);
    drive(16'h0010, 1'b1, 8'h3C);
    step();
    drive(16'h0300, 1'b0, 8'h00);
    step();
    chk("pass_wr", wr_v[16'h0010] ? mem_arr[16'h0010] : 8'h00, 8'h3C);
    to_parity(0);
    trig(8'h02);
    wait_done(1'b0);
    xfer_checks(513, 8'hA5, 8'h5A);
    to_parity(1);
    trig(8'h02);
    wait_done(1'b0);
    xfer_checks(514, 8'hA5, 8'h5A);
    to_parity(0);
    trig(8'hFF);
    wait_done(1'b0);
    xfer_checks(513, 8'h58, 8'hA7);
    chk("ff_min_rd", min_rd, 32'hFF00);
    chk("ff_max_rd", max_rd, 32'hFFFF);
    to_parity(1);
    trig(8'h02);
    wait_done(1'b1);
    xfer_checks(514, 8'hA5, 8'h5A);
    to_parity(0);
    trig(8'h02);
    while (cyc < trig_c + 202) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rdy", cpu_rdy, 1);
    chk("abort_busy", dma_busy, 0);
    chk("abort_done", dma_done, 0);
    clr();
    repeat (600) step();
    chk("abort_writes", wr_cnt, 0);
    chk("abort_pulses", done_cnt, 0);
    to_parity(1);
    trig(8'h02);
    wait_done(1'b0);
    xfer_checks(514, 8'hA5, 8'h5A);
    to_parity(0);
    trig(8'h02);
    wait_done(1'b0);
    trig(8'h02);
    chk("retrig_rdy", cpu_rdy, 0);
    chk("retrig_busy", dma_busy, 1);
    wait_done(1'b0);
    xfer_checks(513, 8'hA5, 8'h5A);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
